// File: rtl/ddr_pi_match_cfg_seq.sv
// ddr_pi_match_cfg_seq: steps the PI match cell config toward a target without glitching GEAR while enabled
module ddr_pi_match_cfg_seq #(
  parameter int PWIDTH = 9,
  parameter int SETTLE_W = 4,
  parameter logic [PWIDTH-1:0] RESET_CFG = '0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req,
  input  logic [PWIDTH-1:0]   i_cfg,
  input  logic [SETTLE_W-1:0] i_settle_cyc,
  output logic [PWIDTH-1:0]   o_pi_cfg,
  output logic                o_busy,
  output logic                o_ack
);
  typedef enum logic [2:0] {IDLE, CHK, DIS, GEAR, STEP, ENA, DONE} state_t;
  state_t state, state_d, rule;
  logic [PWIDTH-1:0] tgt, cfg_d;
  logic [SETTLE_W-1:0] s, cnt;
  logic dec, gear_ne;
  always_comb begin
    gear_ne = o_pi_cfg[4:1] != tgt[4:1];
    dec = state == CHK || (state inside {DIS, GEAR, STEP, ENA} && cnt == '0);
    rule = (o_pi_cfg[0] && (gear_ne || !tgt[0])) ? DIS :
           gear_ne ? GEAR :
           o_pi_cfg[8:5] != tgt[8:5] ? STEP :
           (tgt[0] && !o_pi_cfg[0]) ? ENA : DONE;
    state_d = state == IDLE ? (i_req ? CHK : IDLE) :
              state == DONE ? IDLE :
              dec ? rule : state;
    cfg_d = o_pi_cfg;
    if (dec) begin
      if (rule == DIS) cfg_d[0] = 1'b0;
      if (rule == GEAR) cfg_d[4:1] = tgt[4:1];
      if (rule == STEP) cfg_d[8:5] = o_pi_cfg[8:5] < tgt[8:5] ? o_pi_cfg[8:5] + 4'd1 : o_pi_cfg[8:5] - 4'd1;
      if (rule == ENA) cfg_d[0] = 1'b1;
      // Fields already match here; this also carries any bits beyond the field map
      if (rule == DONE) cfg_d = tgt;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      o_pi_cfg <= RESET_CFG;
      tgt <= '0;
      s <= '0;
      cnt <= '0;
    end else begin
      state <= state_d;
      o_pi_cfg <= cfg_d;
      if (state == IDLE && i_req) begin
        tgt <= i_cfg;
        s <= i_settle_cyc;
      end
      if (dec) cnt <= s;
      else if (cnt != '0) cnt <= cnt - SETTLE_W'(1);
    end
  end
  assign o_busy = state != IDLE;
  assign o_ack = state == DONE;
endmodule

// File: doc/ddr_pi_match_cfg_seq.md
DDR_PI_MATCH_CFG_SEQ -- requirements
Module: ddr_pi_match_cfg_seq

Interface
REQ-001 The block SHALL have parameter PWIDTH, default 9: width of the PI match config word.
REQ-002 The block SHALL have parameter SETTLE_W, default 4: width of the settle-count input.
REQ-003 The block SHALL have parameter RESET_CFG, default 0 (PWIDTH bits): value driven on o_pi_cfg out of reset.
REQ-004 The config word field map SHALL be fixed: EN = bit [0]; GEAR = bits [4:1]; XCPL = bits [8:5].
REQ-005 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port i_req, input, 1 bit: request to move the PI match cell to i_cfg.
REQ-008 The block SHALL have port i_cfg, input, PWIDTH bits: target config word.
REQ-009 The block SHALL have port i_settle_cyc, input, SETTLE_W bits: settle count S; each update step holds S+1 cycles.
REQ-010 The block SHALL have port o_pi_cfg, output, PWIDTH bits: registered config to the PI match delay cell.
REQ-011 The block SHALL have port o_busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 The block SHALL have port o_ack, output, 1 bit: one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have exactly these states: IDLE, CHK, DIS, GEAR, STEP, ENA, DONE.
REQ-014 In IDLE, a rising edge with i_req=1 SHALL latch i_cfg as the target, latch i_settle_cyc as S, and enter CHK.
REQ-015 When the state is not IDLE, i_req SHALL be ignored: no latch and no extra ack.
REQ-016 Every o_pi_cfg change SHALL occur on the clock edge that enters DIS, GEAR, STEP or ENA, and o_pi_cfg SHALL otherwise hold.
REQ-017 DIS, GEAR, each STEP visit and ENA SHALL each last exactly S+1 cycles, counted by a settle counter reloaded on every entry.
REQ-018 From CHK or after a settle expires, the next state SHALL be the first matching rule, in order:
- DIS: current EN=1 and (current GEAR != target GEAR or target EN=0); entry clears EN.
- GEAR: current GEAR != target GEAR; entry writes target GEAR; only reachable with EN=0.
- STEP: current XCPL != target XCPL; entry moves XCPL by +1 or -1 toward the target.
- ENA: target EN=1 and current EN=0; entry sets EN=1.
- DONE: otherwise.
REQ-019 XCPL SHALL change by at most 1 code per STEP entry, with unsigned compare and no wrap-around; a move of N codes SHALL take N STEP visits.
REQ-020 GEAR SHALL never change while EN=1 on o_pi_cfg.
REQ-021 DONE SHALL last 1 cycle with o_ack=1 and o_busy=1, then enter IDLE.
REQ-022 o_ack SHALL be high only in DONE.
REQ-023 o_busy SHALL be high in every state except IDLE.
REQ-024 A target equal to the current o_pi_cfg SHALL take the path IDLE->CHK->DONE->IDLE.
REQ-025 Bits of i_cfg outside the field map (PWIDTH>9) SHALL be copied to o_pi_cfg on DONE entry.

Reset
REQ-026 While i_rst=1 at a clock edge, the block SHALL set o_pi_cfg=RESET_CFG, o_busy=0, o_ack=0, state=IDLE and settle counter=0.
REQ-027 Reset SHALL take priority over i_req and over any in-progress sequence.
REQ-028 A sequence aborted by reset SHALL produce no ack.

Verification
REQ-029 After reset (cfg=0), req i_cfg {EN=1, GEAR=2, XCPL=3} with S=0 at edge E0 -> the bench SHALL see:
- E1: GEAR=2.
- E2/E3/E4: XCPL=1/2/3.
- E5: EN=1.
- o_ack high for the cycle after E6.
- idle at E7.
REQ-030 From {1,2,3}, req XCPL=1 with S=2 -> EN stays 1, XCPL=2 at E1, XCPL=1 at E4, DONE entered at E7, one ack.
REQ-031 From {1,2,3}, req GEAR=5 -> EN falls first, GEAR=5 S+1 cycles later, EN=1 last, and EN=0 whenever GEAR changes.
REQ-032 A req equal to the current cfg -> ack in the cycle after E1, o_pi_cfg unchanged, idle at E2.
REQ-033 i_req pulsed repeatedly while busy -> ignored; exactly one ack per accepted request.
REQ-034 i_rst asserted mid-STEP -> at the next edge o_pi_cfg=RESET_CFG and o_busy=0, with no ack.
